iob_ram_t2p_be_arb: RTL and testbench

Multi-channel arbitrated front end for a two-port (one read, one write) byte-enable RAM in the iob_system memory wrapper. It lets N_CH IOb native-bus masters share one external RAM, with independent round-robin arbitration of the read and write ports so that one read and one write can complete in the same cycle. An optional bypass returns coherent data when a read and a write to the same word are granted together. The RAM macro sits outside this block and is connected to its ram_* ports.

---
 rtl/iob_ram_t2p_be_arb_if.sv | 25 ++
 rtl/iob_ram_t2p_be_arb.sv | 146 ++++++++++++++
 tb/tb_iob_ram_t2p_be_arb.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_ram_t2p_be_arb_if.sv
// IOb native bus bundle for N_CH masters sharing the two-port RAM arbiter.
// Signal names carry the arbiter-side direction suffix.
interface iob_ram_t2p_be_arb_if #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic [N_CH-1:0]            iob_valid_i;
    logic [N_CH*ADDR_W-1:0]     iob_addr_i;
    logic [N_CH*DATA_W-1:0]     iob_wdata_i;
    logic [N_CH*DATA_W/8-1:0]   iob_wstrb_i;
    logic [N_CH-1:0]            iob_ready_o;
    logic [N_CH-1:0]            iob_rvalid_o;
    logic [DATA_W-1:0]          iob_rdata_o;

    modport master (
        output iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
        input  iob_ready_o, iob_rvalid_o, iob_rdata_o
    );

    modport slave (
        input  iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
        output iob_ready_o, iob_rvalid_o, iob_rdata_o
    );
endinterface

// File: rtl/iob_ram_t2p_be_arb.sv
// Round-robin front end sharing one read / one write byte-enable RAM among N_CH
// IOb masters, with optional same-cycle write-to-read bypass.
module iob_ram_t2p_be_arb #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int FWD_EN = 1
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   cke_i,
    iob_ram_t2p_be_arb_if.slave    iob,
    output logic                   ram_r_en_o,
    output logic [ADDR_W-1:0]      ram_r_addr_o,
    input  logic [DATA_W-1:0]      ram_r_data_i,
    output logic [DATA_W/8-1:0]    ram_w_strb_o,
    output logic [ADDR_W-1:0]      ram_w_addr_o,
    output logic [DATA_W-1:0]      ram_w_data_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [N_CH-1:0]   rd_ch_q, rd_ch_d;
    logic              rvalid_q, rvalid_d;
    logic [STRB_W-1:0] fwd_strb_q, fwd_strb_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

    logic              active;
    logic [N_CH-1:0]   rd_req, wr_req, rd_gnt, wr_gnt;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic [N_CH-1:0]   rvalid;
    logic [DATA_W-1:0] rdata;

    // First requester at or after ptr, ascending with wrap.
    function automatic logic [N_CH-1:0] rr_pick(input logic [N_CH-1:0] req,
                                                input logic [PTR_W-1:0] ptr);
        logic [N_CH-1:0] gnt;
        int unsigned     idx;
        gnt = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = (32'(ptr) + i) % N_CH;
            if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
        end
        return gnt;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_after(input logic [N_CH-1:0] gnt);
        logic [PTR_W-1:0] nxt;
        nxt = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (gnt[c]) nxt = (c == N_CH - 1) ? '0 : PTR_W'(c + 1);
        end
        return nxt;
    endfunction

    // Gating requests with reset as well keeps the combinational outputs quiet in reset.
    assign active = cke_i & arst_n_i;

    always_comb begin
        rd_req = '0;
        wr_req = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (active && iob.iob_valid_i[c]) begin
                if (iob.iob_wstrb_i[c*STRB_W +: STRB_W] == '0) rd_req[c] = 1'b1;
                else                                           wr_req[c] = 1'b1;
            end
        end
    end

    assign rd_gnt = rr_pick(rd_req, rd_ptr_q);
    assign wr_gnt = rr_pick(wr_req, wr_ptr_q);

    always_comb begin
        r_addr = '0;
        w_addr = '0;
        w_data = '0;
        w_strb = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (rd_gnt[c]) r_addr = iob.iob_addr_i[c*ADDR_W +: ADDR_W];
            if (wr_gnt[c]) begin
                w_addr = iob.iob_addr_i[c*ADDR_W +: ADDR_W];
                w_data = iob.iob_wdata_i[c*DATA_W +: DATA_W];
                w_strb = iob.iob_wstrb_i[c*STRB_W +: STRB_W];
            end
        end
    end

    assign iob.iob_ready_o = rd_gnt | wr_gnt;
    assign ram_r_en_o      = |rd_gnt;
    assign ram_r_addr_o    = r_addr;
    assign ram_w_strb_o    = w_strb;
    assign ram_w_addr_o    = w_addr;
    assign ram_w_data_o    = w_data;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ch_d    = rd_ch_q;
        rvalid_d   = |rd_gnt;
        fwd_strb_d = '0;
        fwd_data_d = fwd_data_q;
        if (|rd_gnt) begin
            rd_ptr_d = ptr_after(rd_gnt);
            rd_ch_d  = rd_gnt;
        end
        if (|wr_gnt) wr_ptr_d = ptr_after(wr_gnt);
        if ((FWD_EN != 0) && (|rd_gnt) && (|wr_gnt) && (r_addr == w_addr)) begin
            fwd_strb_d = w_strb;
            fwd_data_d = w_data;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ch_q    <= '0;
            rvalid_q   <= 1'b0;
            fwd_strb_q <= '0;
            fwd_data_q <= '0;
        end else if (cke_i) begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ch_q    <= rd_ch_d;
            rvalid_q   <= rvalid_d;
            fwd_strb_q <= fwd_strb_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // The RAM returns pre-write data on a same-address collision; patch strobed lanes.
    always_comb begin
        rdata = ram_r_data_i;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (fwd_strb_q[b]) rdata[b*8 +: 8] = fwd_data_q[b*8 +: 8];
        end
    end

    assign rvalid           = rd_ch_q & {N_CH{rvalid_q & cke_i}};
    assign iob.iob_rvalid_o = rvalid;
    assign iob.iob_rdata_o  = (|rvalid) ? rdata : '0;
endmodule

// File: tb/tb_iob_ram_t2p_be_arb.sv
// Directed bench: two arbiters (FWD_EN=1 and FWD_EN=0) on identical stimulus,
// each with its own RAM model, checked against a bench-side memory and response queue.
module tb_iob_ram_t2p_be_arb;
    localparam int NC = 2;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic arst_n;
    logic cke;
    always #5 clk = ~clk;

    logic [NC-1:0]    valid;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] wdata;
    logic [NC*SW-1:0] wstrb;

    iob_ram_t2p_be_arb_if #(.N_CH(NC), .DATA_W(DW), .ADDR_W(AW)) bus1 ();
    iob_ram_t2p_be_arb_if #(.N_CH(NC), .DATA_W(DW), .ADDR_W(AW)) bus0 ();

    assign bus1.iob_valid_i = valid;
    assign bus1.iob_addr_i  = addr;
    assign bus1.iob_wdata_i = wdata;
    assign bus1.iob_wstrb_i = wstrb;
    assign bus0.iob_valid_i = valid;
    assign bus0.iob_addr_i  = addr;
    assign bus0.iob_wdata_i = wdata;
    assign bus0.iob_wstrb_i = wstrb;

    logic          r_en1, r_en0;
    logic [AW-1:0] raddr1, raddr0, waddr1, waddr0;
    logic [DW-1:0] rdat1, rdat0, wdat1, wdat0;
    logic [SW-1:0] ws1, ws0;

    iob_ram_t2p_be_arb #(.N_CH(NC), .DATA_W(DW), .ADDR_W(AW), .FWD_EN(1)) dut1 (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .iob(bus1),
        .ram_r_en_o(r_en1), .ram_r_addr_o(raddr1), .ram_r_data_i(rdat1),
        .ram_w_strb_o(ws1), .ram_w_addr_o(waddr1), .ram_w_data_o(wdat1)
    );

    iob_ram_t2p_be_arb #(.N_CH(NC), .DATA_W(DW), .ADDR_W(AW), .FWD_EN(0)) dut0 (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .iob(bus0),
        .ram_r_en_o(r_en0), .ram_r_addr_o(raddr0), .ram_r_data_i(rdat0),
        .ram_w_strb_o(ws0), .ram_w_addr_o(waddr0), .ram_w_data_o(wdat0)
    );

    // Registered-read RAMs: a same-address read sees the pre-write contents.
    logic [DW-1:0] mem1 [0:255];
    logic [DW-1:0] mem0 [0:255];
    always @(posedge clk) begin
        if (r_en1) rdat1 <= mem1[raddr1];
        for (int b = 0; b < SW; b++) if (ws1[b]) mem1[waddr1][b*8 +: 8] <= wdat1[b*8 +: 8];
    end
    always @(posedge clk) begin
        if (r_en0) rdat0 <= mem0[raddr0];
        for (int b = 0; b < SW; b++) if (ws0[b]) mem0[waddr0][b*8 +: 8] <= wdat0[b*8 +: 8];
    end

    typedef struct packed {
        logic [NC-1:0] ch;
        logic [DW-1:0] d1;
        logic [DW-1:0] d0;
    } rsp_t;

    rsp_t          sb[$];
    logic [DW-1:0] ref_mem [0:255];
    int            vectors     = 0;
    int            miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int c, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        valid[c]            = v;
        addr[c*AW +: AW]    = a;
        wdata[c*DW +: DW]   = d;
        wstrb[c*SW +: SW]   = s;
    endtask

    task automatic idle();
        valid = '0;
        addr  = '0;
        wdata = '0;
        wstrb = '0;
    endtask

    // One clock cycle: check outputs at the falling edge, then predict what this cycle commits.
    task automatic cyc(input string tag, input logic [NC-1:0] e_rdy, input logic e_ren,
                       input logic [AW-1:0] e_raddr, input logic [SW-1:0] e_wstrb,
                       input logic [AW-1:0] e_waddr, input logic [DW-1:0] e_wdata);
        rsp_t          h;
        logic [NC-1:0] e_rv;
        logic [DW-1:0] e_d1, e_d0, old, mrg;
        int            rc, wc;
        @(negedge clk);
        if (!arst_n) sb.delete();
        e_rv = '0;
        e_d1 = '0;
        e_d0 = '0;
        if (arst_n && cke && sb.size() > 0) begin
            h    = sb.pop_front();
            e_rv = h.ch;
            e_d1 = h.d1;
            e_d0 = h.d0;
        end
        chk({tag, ".rvalid_fwd"}, 64'(bus1.iob_rvalid_o), 64'(e_rv));
        chk({tag, ".rdata_fwd"},  64'(bus1.iob_rdata_o),  64'(e_d1));
        chk({tag, ".rvalid_raw"}, 64'(bus0.iob_rvalid_o), 64'(e_rv));
        chk({tag, ".rdata_raw"},  64'(bus0.iob_rdata_o),  64'(e_d0));
        chk({tag, ".ready_fwd"},  64'(bus1.iob_ready_o),  64'(e_rdy));
        chk({tag, ".ready_raw"},  64'(bus0.iob_ready_o),  64'(e_rdy));
        chk({tag, ".r_en"},       64'(r_en1),             64'(e_ren));
        chk({tag, ".r_addr"},     64'(raddr1),            64'(e_raddr));
        chk({tag, ".w_strb"},     64'(ws1),               64'(e_wstrb));
        chk({tag, ".w_addr"},     64'(waddr1),            64'(e_waddr));
        chk({tag, ".w_data"},     64'(wdat1),             64'(e_wdata));

        rc = -1;
        wc = -1;
        for (int c = 0; c < NC; c++) begin
            if (e_rdy[c]) begin
                if (wstrb[c*SW +: SW] == '0) rc = c;
                else                         wc = c;
            end
        end
        if (rc >= 0) begin
            old = ref_mem[addr[rc*AW +: AW]];
            mrg = old;
            if (wc >= 0 && addr[wc*AW +: AW] == addr[rc*AW +: AW]) begin
                for (int b = 0; b < SW; b++)
                    if (wstrb[wc*SW + b]) mrg[b*8 +: 8] = wdata[wc*DW + b*8 +: 8];
            end
            h.ch     = '0;
            h.ch[rc] = 1'b1;
            h.d1     = mrg;
            h.d0     = old;
            sb.push_back(h);
        end
        if (wc >= 0) begin
            for (int b = 0; b < SW; b++)
                if (wstrb[wc*SW + b])
                    ref_mem[addr[wc*AW +: AW]][b*8 +: 8] = wdata[wc*DW + b*8 +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n = 1'b0;
        cke    = 1'b1;
        idle();
        drive(0, 1'b1, 8'd5, '0, '0);
        drive(1, 1'b1, 8'd6, '0, '0);
        cyc("rst_a", 2'b00, 1'b0, 8'd0, 4'h0, 8'd0, 32'h0);
        cyc("rst_b", 2'b00, 1'b0, 8'd0, 4'h0, 8'd0, 32'h0);
        idle();
        arst_n = 1'b1;

        drive(0, 1'b1, 8'd5, 32'hA5A5A5A5, 4'hF);
        cyc("pre5", 2'b01, 1'b0, 8'd0, 4'hF, 8'd5, 32'hA5A5A5A5);
        drive(0, 1'b1, 8'd6, 32'h66666666, 4'hF);
        cyc("pre6", 2'b01, 1'b0, 8'd0, 4'hF, 8'd6, 32'h66666666);
        drive(0, 1'b1, 8'd7, 32'h77777777, 4'hF);
        cyc("pre7", 2'b01, 1'b0, 8'd0, 4'hF, 8'd7, 32'h77777777);
        drive(0, 1'b1, 8'd9, 32'hAABBCCDD, 4'hF);
        cyc("pre9", 2'b01, 1'b0, 8'd0, 4'hF, 8'd9, 32'hAABBCCDD);

        idle();
        drive(0, 1'b1, 8'd5, '0, '0);
        cyc("rd5", 2'b01, 1'b1, 8'd5, 4'h0, 8'd0, 32'h0);
        idle();
        cyc("rd5_rsp", 2'b00, 1'b0, 8'd0, 4'h0, 8'd0, 32'h0);
        cyc("rd5_after", 2'b00, 1'b0, 8'd0, 4'h0, 8'd0, 32'h0);

        drive(0, 1'b1, 8'd5, '0, '0);
        cyc("mid_acc", 2'b01, 1'b1, 8'd5, 4'h0, 8'd0, 32'h0);
        #3;
        arst_n = 1'b0;
        drive(0, 1'b1, 8'd6, '0, '0);
        drive(1, 1'b1, 8'd7, '0, '0);
        cyc("mid_rst", 2'b00, 1'b0, 8'd0, 4'h0, 8'd0, 32'h0);
        idle();
        arst_n = 1'b1;
        cyc("mid_post", 2'b00, 1'b0, 8'd0, 4'h0, 8'd0, 32'h0);

        drive(0, 1'b1, 8'd5, '0, '0);
        drive(1, 1'b1, 8'd6, '0, '0);
        for (int i = 0; i < 6; i++)
            cyc($sformatf("rr%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1,
                (i % 2 == 0) ? 8'd5 : 8'd6, 4'h0, 8'd0, 32'h0);
        idle();
        cyc("rr_drain", 2'b00, 1'b0, 8'd0, 4'h0, 8'd0, 32'h0);

        drive(0, 1'b1, 8'd3, 32'h11223344, 4'hF);
        drive(1, 1'b1, 8'd7, '0, '0);
        cyc("par", 2'b11, 1'b1, 8'd7, 4'hF, 8'd3, 32'h11223344);
        idle();
        drive(0, 1'b1, 8'd3, '0, '0);
        cyc("par_rb", 2'b01, 1'b1, 8'd3, 4'h0, 8'd0, 32'h0);
        idle();
        cyc("par_rb_rsp", 2'b00, 1'b0, 8'd0, 4'h0, 8'd0, 32'h0);

        drive(0, 1'b1, 8'd9, 32'h00001122, 4'h3);
        drive(1, 1'b1, 8'd9, '0, '0);
        cyc("byp", 2'b11, 1'b1, 8'd9, 4'h3, 8'd9, 32'h00001122);
        idle();
        drive(1, 1'b1, 8'd9, '0, '0);
        cyc("byp_rb", 2'b10, 1'b1, 8'd9, 4'h0, 8'd0, 32'h0);
        idle();
        cyc("byp_rb_rsp", 2'b00, 1'b0, 8'd0, 4'h0, 8'd0, 32'h0);

        drive(0, 1'b1, 8'd20, 32'hC0C0C0C0, 4'hF);
        drive(1, 1'b1, 8'd21, 32'hC1C1C1C1, 4'hF);
        cyc("wrr0", 2'b10, 1'b0, 8'd0, 4'hF, 8'd21, 32'hC1C1C1C1);
        drive(1, 1'b0, 8'd0, '0, '0);
        cyc("wrr1", 2'b01, 1'b0, 8'd0, 4'hF, 8'd20, 32'hC0C0C0C0);
        idle();
        drive(0, 1'b1, 8'd20, '0, '0);
        drive(1, 1'b1, 8'd21, '0, '0);
        cyc("wrr_rb0", 2'b01, 1'b1, 8'd20, 4'h0, 8'd0, 32'h0);
        drive(0, 1'b0, 8'd0, '0, '0);
        cyc("wrr_rb1", 2'b10, 1'b1, 8'd21, 4'h0, 8'd0, 32'h0);
        idle();
        cyc("wrr_rb_rsp", 2'b00, 1'b0, 8'd0, 4'h0, 8'd0, 32'h0);

        drive(0, 1'b1, 8'd5, '0, '0);
        cyc("cke_acc", 2'b01, 1'b1, 8'd5, 4'h0, 8'd0, 32'h0);
        cke = 1'b0;
        idle();
        drive(1, 1'b1, 8'd6, '0, '0);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("cke_low%0d", i), 2'b00, 1'b0, 8'd0, 4'h0, 8'd0, 32'h0);
        cke = 1'b1;
        cyc("cke_rsp", 2'b10, 1'b1, 8'd6, 4'h0, 8'd0, 32'h0);
        idle();
        cyc("cke_rsp2", 2'b00, 1'b0, 8'd0, 4'h0, 8'd0, 32'h0);
        cyc("cke_end", 2'b00, 1'b0, 8'd0, 4'h0, 8'd0, 32'h0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
